// File: rtl/seq_chk_pkg.sv
// rtl/seq_chk_pkg.sv - shared types and helpers for the seq_chk_mon sequence checker
package seq_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_GAP,
      ST_DLY,
      ST_WIN
   } chan_state_e;

   // Counter width able to hold 0..n; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   localparam int DEF_MAX_GAP = 2;
   localparam int DEF_CHK_DLY = 1;
   localparam int DEF_CHK_WIN = 1;
   localparam int DEF_GAP_W   = cnt_width(DEF_MAX_GAP);
   localparam int DEF_DLY_W   = cnt_width(DEF_CHK_DLY);
   localparam int DEF_WIN_W   = cnt_width(DEF_CHK_WIN);

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] lim);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, lim}) ? lim : s[31:0];
   endfunction

endpackage

// File: rtl/seq_chk_chan.sv
// rtl/seq_chk_chan.sv - one checker channel: pulse-gap-pulse antecedent, delayed response window
// Optional match output under SEQ_CHK_MON_COVER_EN.
module seq_chk_chan
   import seq_chk_pkg::*;
#(
   parameter int MIN_GAP = 1,
   parameter int MAX_GAP = DEF_MAX_GAP,
   parameter int CHK_DLY = DEF_CHK_DLY,
   parameter int CHK_WIN = DEF_CHK_WIN
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic trig_i,
   input  logic resp_i,
`ifdef SEQ_CHK_MON_COVER_EN
   output logic match_o,
`endif
   output logic pass_o,
   output logic fail_o
);

   localparam int GAP_W = cnt_width(MAX_GAP);
   localparam int DLY_W = cnt_width(CHK_DLY);
   localparam int WIN_W = cnt_width(CHK_WIN);

   localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(MIN_GAP);
   localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MAX_GAP);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(CHK_DLY - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CHK_WIN - 1);

   chan_state_e      state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
`ifdef SEQ_CHK_MON_COVER_EN
   logic             match_q, match_d;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         dly_q   <= '0;
         win_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
`ifdef SEQ_CHK_MON_COVER_EN
         match_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         dly_q   <= dly_d;
         win_q   <= win_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
`ifdef SEQ_CHK_MON_COVER_EN
         match_q <= match_d;
`endif
      end
   end

   // gap_q counts low cycles seen so far; win_q counts window samples already taken.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      dly_d   = dly_q;
      win_d   = win_q;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
`ifdef SEQ_CHK_MON_COVER_EN
      match_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: if (trig_i) state_d = ST_ARM;
         ST_ARM: begin
            if (!trig_i) begin
               state_d = ST_GAP;
               gap_d   = GAP_W'(1);
            end
         end
         ST_GAP: begin
            if (!trig_i) begin
               if (gap_q == GAP_MAX) state_d = ST_IDLE;
               else                  gap_d   = gap_q + 1'b1;
            end else if (gap_q >= GAP_MIN) begin
`ifdef SEQ_CHK_MON_COVER_EN
               match_d = 1'b1;
`endif
               // With no delay the matching cycle is itself the first window sample.
               if (CHK_DLY == 0) begin
                  if (resp_i) begin
                     pass_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else if (CHK_WIN == 1) begin
                     fail_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_WIN;
                     win_d   = WIN_W'(1);
                  end
               end else if (CHK_DLY == 1) begin
                  state_d = ST_WIN;
                  win_d   = '0;
               end else begin
                  state_d = ST_DLY;
                  dly_d   = DLY_W'(1);
               end
            end else begin
               state_d = ST_ARM;
            end
         end
         ST_DLY: begin
            if (dly_q == DLY_LAST) begin
               state_d = ST_WIN;
               win_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         ST_WIN: begin
            if (resp_i) begin
               pass_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (win_q == WIN_LAST) begin
               fail_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               win_d = win_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!en_i) begin
         state_d = ST_IDLE;
         pass_d  = 1'b0;
         fail_d  = 1'b0;
`ifdef SEQ_CHK_MON_COVER_EN
         match_d = 1'b0;
`endif
      end
   end

   always_comb begin
      pass_o  = pass_q;
      fail_o  = fail_q;
`ifdef SEQ_CHK_MON_COVER_EN
      match_o = match_q;
`endif
   end

endmodule

// File: rtl/seq_chk_mon.sv
// rtl/seq_chk_mon.sv - multi-channel sequence checker with saturating pass/fail counters
// SEQ_CHK_MON_COVER_EN adds cov_cnt, a saturating count of antecedent matches.
module seq_chk_mon
   import seq_chk_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int MIN_GAP = 1,
   parameter int MAX_GAP = DEF_MAX_GAP,
   parameter int CHK_DLY = DEF_CHK_DLY,
   parameter int CHK_WIN = DEF_CHK_WIN,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [NCH-1:0]   trig,
   input  logic [NCH-1:0]   resp,
   output logic [NCH-1:0]   pass_p,
   output logic [NCH-1:0]   fail_p,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
`ifdef SEQ_CHK_MON_COVER_EN
   output logic [CNT_W-1:0] cov_cnt,
`endif
   output logic             err_sticky
);

   generate
      if (MIN_GAP < 1 || MAX_GAP < MIN_GAP || MAX_GAP > 255 || CHK_DLY < 0 ||
          CHK_WIN < 1 || NCH < 1 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
         $fatal(1, "seq_chk_mon: illegal parameter combination");
      end
   endgenerate

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             err_q, err_d;
`ifdef SEQ_CHK_MON_COVER_EN
   logic [NCH-1:0]   match;
   logic [CNT_W-1:0] cov_cnt_q, cov_cnt_d;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      seq_chk_chan #(
         .MIN_GAP (MIN_GAP),
         .MAX_GAP (MAX_GAP),
         .CHK_DLY (CHK_DLY),
         .CHK_WIN (CHK_WIN)
      ) u_chan (
         .clk_i   (clk),
         .rst_i   (rst),
         .en_i    (en),
         .trig_i  (trig[i]),
         .resp_i  (resp[i]),
`ifdef SEQ_CHK_MON_COVER_EN
         .match_o (match[i]),
`endif
         .pass_o  (pass_p[i]),
         .fail_o  (fail_p[i])
      );
   end

   // Counters consume the registered pulses, so they trail pass_p/fail_p by one cycle.
   always_comb begin
      pass_cnt_d = clr ? '0 : CNT_W'(sat_add(32'(pass_cnt_q), 32'($countones(pass_p)), CNT_MAX));
      fail_cnt_d = clr ? '0 : CNT_W'(sat_add(32'(fail_cnt_q), 32'($countones(fail_p)), CNT_MAX));
      err_d      = clr ? 1'b0 : (err_q | (|fail_p));
`ifdef SEQ_CHK_MON_COVER_EN
      cov_cnt_d  = clr ? '0 : CNT_W'(sat_add(32'(cov_cnt_q), 32'($countones(match)), CNT_MAX));
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         err_q      <= 1'b0;
`ifdef SEQ_CHK_MON_COVER_EN
         cov_cnt_q  <= '0;
`endif
      end else begin
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         err_q      <= err_d;
`ifdef SEQ_CHK_MON_COVER_EN
         cov_cnt_q  <= cov_cnt_d;
`endif
      end
   end

   always_comb begin
      pass_cnt   = pass_cnt_q;
      fail_cnt   = fail_cnt_q;
      err_sticky = err_q;
`ifdef SEQ_CHK_MON_COVER_EN
      cov_cnt    = cov_cnt_q;
`endif
   end

endmodule

// File: tb/tb_seq_chk_mon.sv
// tb/tb_seq_chk_mon.sv - scoreboard bench for seq_chk_mon across three parameter sets
module tb_seq_chk_mon;

   typedef struct packed {
      logic [3:0]  p;
      logic [3:0]  f;
      logic [31:0] pc;
      logic [31:0] fc;
      logic [31:0] cc;
      logic        err;
   } exp_t;

   localparam int P_MIN[3] = '{1, 2, 1};
   localparam int P_MAX[3] = '{2, 3, 4};
   localparam int P_DLY[3] = '{1, 0, 2};
   localparam int P_WIN[3] = '{1, 3, 2};
   localparam int P_CW[3]  = '{16, 3, 8};

   logic       clk;
   logic       rst, en, clr;
   logic [3:0] trig, resp;
   logic [3:0] pp[3];
   logic [3:0] fp[3];
   logic       errv[3];
   logic [15:0] pc_a, fc_a;
   logic [2:0]  pc_b, fc_b;
   logic [7:0]  pc_c, fc_c;
   int          pcnt_o[3];
   int          fcnt_o[3];
`ifdef SEQ_CHK_MON_COVER_EN
   logic [15:0] cc_a;
   logic [2:0]  cc_b;
   logic [7:0]  cc_c;
   int          ccnt_o[3];
   assign ccnt_o[0] = 32'(cc_a);
   assign ccnt_o[1] = 32'(cc_b);
   assign ccnt_o[2] = 32'(cc_c);
`endif
   assign pcnt_o[0] = 32'(pc_a);
   assign pcnt_o[1] = 32'(pc_b);
   assign pcnt_o[2] = 32'(pc_c);
   assign fcnt_o[0] = 32'(fc_a);
   assign fcnt_o[1] = 32'(fc_b);
   assign fcnt_o[2] = 32'(fc_c);

   seq_chk_mon #(.NCH(4), .MIN_GAP(1), .MAX_GAP(2), .CHK_DLY(1), .CHK_WIN(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .resp(resp),
      .pass_p(pp[0]), .fail_p(fp[0]), .pass_cnt(pc_a), .fail_cnt(fc_a),
`ifdef SEQ_CHK_MON_COVER_EN
      .cov_cnt(cc_a),
`endif
      .err_sticky(errv[0]));

   seq_chk_mon #(.NCH(4), .MIN_GAP(2), .MAX_GAP(3), .CHK_DLY(0), .CHK_WIN(3), .CNT_W(3)) u_b (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .resp(resp),
      .pass_p(pp[1]), .fail_p(fp[1]), .pass_cnt(pc_b), .fail_cnt(fc_b),
`ifdef SEQ_CHK_MON_COVER_EN
      .cov_cnt(cc_b),
`endif
      .err_sticky(errv[1]));

   seq_chk_mon #(.NCH(4), .MIN_GAP(1), .MAX_GAP(4), .CHK_DLY(2), .CHK_WIN(2), .CNT_W(8)) u_c (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .resp(resp),
      .pass_p(pp[2]), .fail_p(fp[2]), .pass_cnt(pc_c), .fail_cnt(fc_c),
`ifdef SEQ_CHK_MON_COVER_EN
      .cov_cnt(cc_c),
`endif
      .err_sticky(errv[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t expq[3][$];

   // Reference model: timestamps of the last trig high and of the pending window.
   bit         busy[3][4];
   bit         armed[3][4];
   int         last_hi[3][4];
   int         wstart[3][4];
   int         wend[3][4];
   int         m_pc[3], m_fc[3], m_cc[3];
   bit         m_err[3];
   logic [3:0] prev_p[3], prev_f[3];
   int         prev_m[3];

   task automatic check(input string name, input int inst, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s u%0d: got %0d expected %0d (t=%0t)", name, inst, act, exp, $time);
      end
   endtask

   function automatic int pop4(input logic [3:0] v);
      int n = 0;
      for (int k = 0; k < 4; k++) n += int'(v[k]);
      return n;
   endfunction

   function automatic int sat(input int v, input int w);
      int lim = (1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   task automatic model(input bit r, input bit e, input bit c, input logic [3:0] t, input logic [3:0] rs);
      exp_t       x;
      logic [3:0] np, nf;
      int         nm, gap;
      bit         wasb;
      for (int m = 0; m < 3; m++) begin
         if (r) begin
            for (int ch = 0; ch < 4; ch++) begin
               busy[m][ch]  = 1'b0;
               armed[m][ch] = 1'b0;
            end
            m_pc[m] = 0; m_fc[m] = 0; m_cc[m] = 0; m_err[m] = 1'b0;
            prev_p[m] = '0; prev_f[m] = '0; prev_m[m] = 0;
            x = '0;
         end else begin
            m_pc[m]  = c ? 0 : sat(m_pc[m] + pop4(prev_p[m]), P_CW[m]);
            m_fc[m]  = c ? 0 : sat(m_fc[m] + pop4(prev_f[m]), P_CW[m]);
            m_cc[m]  = c ? 0 : sat(m_cc[m] + prev_m[m], P_CW[m]);
            m_err[m] = c ? 1'b0 : (m_err[m] | (prev_f[m] != 4'd0));
            np = '0; nf = '0; nm = 0;
            for (int ch = 0; ch < 4; ch++) begin
               if (!e) begin
                  busy[m][ch]  = 1'b0;
                  armed[m][ch] = 1'b0;
               end else begin
                  wasb = busy[m][ch];
                  if (!wasb) begin
                     if (t[ch]) begin
                        gap = cyc - last_hi[m][ch] - 1;
                        if (armed[m][ch] && gap >= P_MIN[m]) begin
                           busy[m][ch]   = 1'b1;
                           armed[m][ch]  = 1'b0;
                           wstart[m][ch] = cyc + P_DLY[m];
                           wend[m][ch]   = cyc + P_DLY[m] + P_WIN[m] - 1;
                           nm++;
                        end else begin
                           armed[m][ch]   = 1'b1;
                           last_hi[m][ch] = cyc;
                        end
                     end else if (armed[m][ch] && (cyc - last_hi[m][ch]) > P_MAX[m]) begin
                        armed[m][ch] = 1'b0;
                     end
                  end
                  if (busy[m][ch] && cyc >= wstart[m][ch]) begin
                     if (rs[ch]) begin
                        np[ch] = 1'b1;
                        busy[m][ch] = 1'b0;
                     end else if (cyc == wend[m][ch]) begin
                        nf[ch] = 1'b1;
                        busy[m][ch] = 1'b0;
                     end
                  end
               end
            end
            prev_p[m] = np; prev_f[m] = nf; prev_m[m] = nm;
            x.p = np; x.f = nf; x.pc = m_pc[m]; x.fc = m_fc[m]; x.cc = m_cc[m]; x.err = m_err[m];
         end
         expq[m].push_back(x);
      end
   endtask

   task automatic step(input bit r, input bit e, input bit c, input logic [3:0] t, input logic [3:0] rs);
      @(negedge clk);
      rst = r; en = e; clr = c; trig = t; resp = rs;
      model(r, e, c, t, rs);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
   endtask

   // Monitor: one expected record per instance per clock, compared just after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         for (int m = 0; m < 3; m++) begin
            if (expq[m].size() > 0) begin
               x = expq[m].pop_front();
               check("pass_p", m, pp[m], x.p);
               check("fail_p", m, fp[m], x.f);
               check("pass_cnt", m, pcnt_o[m], x.pc);
               check("fail_cnt", m, fcnt_o[m], x.fc);
               check("err_sticky", m, errv[m], x.err);
`ifdef SEQ_CHK_MON_COVER_EN
               check("cov_cnt", m, ccnt_o[m], x.cc);
`endif
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; trig = '0; resp = '0;
      step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check("reset_pass_cnt", 0, pcnt_o[0], 0);
      check("reset_err", 0, errv[0], 0);
      idle(1);

      // ch0 pulse-gap-pulse then resp next cycle
      step(0, 1, 0, 4'b0001, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0000);
      step(0, 1, 0, 4'b0001, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0001);
      idle(6);
      check("a_pass_after_ch0", 0, pcnt_o[0], 1);
      check("a_err_after_ch0", 0, errv[0], 0);

      // ch1 gap 2, resp withheld
      step(0, 1, 0, 4'b0010, 4'b0000);
      idle(2);
      step(0, 1, 0, 4'b0010, 4'b0000);
      idle(6);
      check("a_fail_after_ch1", 0, fcnt_o[0], 1);
      check("a_err_after_ch1", 0, errv[0], 1);
      step(0, 1, 1, 4'd0, 4'd0);
      idle(1);
      check("a_err_after_clr", 0, errv[0], 0);
      check("a_pass_after_clr", 0, pcnt_o[0], 0);

      // ch2 gap 3 aborts; then re-anchor and match at gap 1
      step(0, 1, 0, 4'b0100, 4'b0000);
      idle(3);
      step(0, 1, 0, 4'b0100, 4'b0000);
      idle(6);
      step(0, 1, 0, 4'b0100, 4'b0000);
      step(0, 1, 0, 4'b0100, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0000);
      step(0, 1, 0, 4'b0100, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0100);
      idle(6);
      check("a_pass_reanchor", 0, pcnt_o[0], 1);
      check("a_fail_gap3", 0, fcnt_o[0], 0);

      // all four channels pass together
      step(0, 1, 0, 4'b1111, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0000);
      step(0, 1, 0, 4'b1111, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b1111);
      idle(6);
      check("a_pass_all4", 0, pcnt_o[0], 5);

      // two rounds of four passes on the 3-bit counter instance
      for (int rnd = 0; rnd < 2; rnd++) begin
         step(0, 1, 0, 4'b1111, 4'b0000);
         idle(2);
         step(0, 1, 0, 4'b1111, 4'b1111);
         step(0, 1, 0, 4'b0000, 4'b1111);
         idle(6);
      end
      check("b_pass_saturated", 1, pcnt_o[1], 7);
      check("a_pass_rounds", 0, pcnt_o[0], 13);

      // reset while ch0 of u_a sits in its window
      step(0, 1, 0, 4'b0001, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0000);
      step(0, 1, 0, 4'b0001, 4'b0000);
      step(1, 1, 0, 4'b0000, 4'b0000);
      #1;
      check("a_pass_cnt_rst_now", 0, pcnt_o[0], 0);
      check("a_fail_p_rst_now", 0, fp[0], 0);
      idle(6);

      // en dropped mid-gap
      step(0, 1, 0, 4'b0001, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 4'b0000, 4'b0000);
      step(0, 1, 0, 4'b0001, 4'b0000);
      idle(6);
      check("a_pass_en_abort", 0, pcnt_o[0], 0);
      check("a_fail_en_abort", 0, fcnt_o[0], 0);

      // zero-delay, three-cycle window: resp on the third window sample
      step(0, 1, 0, 4'b0001, 4'b0000);
      idle(2);
      step(0, 1, 0, 4'b0001, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0000);
      step(0, 1, 0, 4'b0000, 4'b0001);
      idle(6);
      check("b_pass_win3", 1, pcnt_o[1], 1);
      check("b_fail_win3", 1, fcnt_o[1], 0);
`ifdef SEQ_CHK_MON_COVER_EN
      check("b_cov_win3", 1, ccnt_o[1], 1);
`endif

      for (int k = 0; k < 4000; k++) begin
         logic [3:0] t, rs;
         bit r, e, c;
         for (int b = 0; b < 4; b++) begin
            t[b]  = ($urandom_range(0, 99) < 40);
            rs[b] = ($urandom_range(0, 99) < 30);
         end
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 99) >= 3);
         c = ($urandom_range(0, 99) < 2);
         step(r, e, c, t, rs);
      end
      idle(4);

      @(posedge clk);
      #2;
      for (int m = 0; m < 3; m++) check("scoreboard_drain", m, expq[m].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
